// File: rtl/databreak_ctrl.sv
// Data-break (DMA) controller: steals one RAM cycle from the CPU at an instruction boundary.
// Optional read-increment-write requests are enabled by defining DATABREAK_MEMINC_EN.
module databreak_ctrl #(
  parameter int PRIO_FIXED = 0,
  parameter int STALL_MAX  = 15
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        BRK_OK,
  input  logic        CPU_HALTED,
  output logic        CPU_STALL,
  output logic        BUS_OWN,
  output logic [11:0] RAM_ADDR,
  output logic [11:0] RAM_WDATA,
  input  logic [11:0] RAM_RDATA,
  output logic        RAM_OE,
  output logic        RAM_WE,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [11:0] ADDR0,
  input  logic [11:0] ADDR1,
  input  logic        WR0,
  input  logic        WR1,
  input  logic [11:0] WDATA0,
  input  logic [11:0] WDATA1,
`ifdef DATABREAK_MEMINC_EN
  input  logic        INC0,
  input  logic        INC1,
  output logic        OVF,
`endif
  output logic        ACK0,
  output logic        ACK1,
  output logic [11:0] RDATA,
  output logic        ERR
);

  localparam int CNT_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ADDR, S_DATA, S_WRITE, S_ACK
  } state_t;

  state_t           state, state_d;
  logic             gnt_q, wr_q, inc_q, last_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      addr_q, wdata_q, rdata_q;
  logic             win, inc_sel, brk, timeout, any_req;

  function automatic logic [11:0] inc12(input logic [11:0] v);
    return v + 12'd1;
  endfunction

  assign any_req = REQ0 | REQ1;
  assign brk     = BRK_OK | CPU_HALTED;
  assign timeout = (STALL_MAX != 0) && (cnt_q == CNT_W'(STALL_MAX - 1));

  // On contention the requester not served last wins, unless priority is fixed.
  always_comb begin
    win = ~REQ0;
    if (REQ0 && REQ1) win = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
  end

`ifdef DATABREAK_MEMINC_EN
  assign inc_sel = win ? (INC1 & ~WR1) : (INC0 & ~WR0);
  assign OVF     = (state == S_ACK) && inc_q && (rdata_q == 12'd0);
`else
  assign inc_sel = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (any_req) state_d = S_WAIT;
      S_WAIT: begin
        if (brk)          state_d = S_ADDR;
        else if (timeout) state_d = S_IDLE;
      end
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = inc_q ? S_WRITE : S_ACK;
      S_WRITE: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      inc_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 12'd0;
    end else begin
      state <= state_d;
      err_q <= (state == S_WAIT) && !brk && timeout;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt_q <= win;
            wr_q  <= win ? WR1 : WR0;
            inc_q <= inc_sel;
          end
          cnt_q <= '0;
        end
        S_WAIT:  cnt_q <= cnt_q + CNT_W'(1);
        S_DATA:  if (!wr_q) rdata_q <= RAM_RDATA;
        S_WRITE: rdata_q <= inc12(rdata_q);
        S_ACK:   last_q <= gnt_q;
        default: ;
      endcase
    end
  end

  // Transaction address/data are only observed while the bus is owned, so no reset.
  always_ff @(posedge SYSCLK) begin
    if (state == S_IDLE && any_req) begin
      addr_q  <= win ? ADDR1 : ADDR0;
      wdata_q <= win ? WDATA1 : WDATA0;
    end
  end

  always_comb begin
    CPU_STALL = (state == S_WAIT) || (state == S_ADDR) || (state == S_DATA) || (state == S_WRITE);
    BUS_OWN   = (state == S_ADDR) || (state == S_DATA) || (state == S_WRITE);
    RAM_OE    = (state == S_ADDR) && !wr_q;
    RAM_WE    = ((state == S_ADDR) && wr_q) || (state == S_WRITE);
    RAM_ADDR  = BUS_OWN ? addr_q : 12'd0;
    RAM_WDATA = 12'd0;
    if ((state == S_ADDR) && wr_q) RAM_WDATA = wdata_q;
    else if (state == S_WRITE)     RAM_WDATA = inc12(rdata_q);
    ACK0      = (state == S_ACK) && !gnt_q;
    ACK1      = (state == S_ACK) && gnt_q;
    RDATA     = rdata_q;
    ERR       = err_q;
  end

endmodule

// File: tb/tb_databreak_ctrl.sv
// Directed bench for databreak_ctrl with a behavioural 4K x 12 RAM.
// Round-robin main instance plus a fixed-priority instance sharing the requester inputs.
module tb_databreak_ctrl;

  logic        SYSCLK = 1'b0;
  logic        RESET, BRK_OK, CPU_HALTED;
  logic        REQ0, REQ1, WR0, WR1;
  logic [11:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic        CPU_STALL, BUS_OWN, RAM_OE, RAM_WE, ACK0, ACK1, ERR;
  logic [11:0] RAM_ADDR, RAM_WDATA, RDATA;
  logic [11:0] ram_rdata;
  logic        fx_stall, fx_own, fx_oe, fx_we, fx_ack0, fx_ack1, fx_err;
  logic [11:0] fx_addr, fx_wdata, fx_rdata;
  logic [11:0] fx_ram_rdata;
`ifdef DATABREAK_MEMINC_EN
  logic        INC0, INC1, OVF, fx_ovf;
`endif

  logic [11:0] mem [0:4095];
  int nvec = 0;
  int nmis = 0;

  always #5 SYSCLK = ~SYSCLK;

  always @(posedge SYSCLK) begin
    if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
    if (RAM_OE) ram_rdata <= mem[RAM_ADDR];
  end

  databreak_ctrl #(.PRIO_FIXED(0), .STALL_MAX(15)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .BRK_OK(BRK_OK), .CPU_HALTED(CPU_HALTED),
    .CPU_STALL(CPU_STALL), .BUS_OWN(BUS_OWN), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(ram_rdata), .RAM_OE(RAM_OE), .RAM_WE(RAM_WE),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1), .WR0(WR0), .WR1(WR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
`ifdef DATABREAK_MEMINC_EN
    .INC0(INC0), .INC1(INC1), .OVF(OVF),
`endif
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR));

  databreak_ctrl #(.PRIO_FIXED(1), .STALL_MAX(15)) dut_fx (
    .SYSCLK(SYSCLK), .RESET(RESET), .BRK_OK(BRK_OK), .CPU_HALTED(CPU_HALTED),
    .CPU_STALL(fx_stall), .BUS_OWN(fx_own), .RAM_ADDR(fx_addr), .RAM_WDATA(fx_wdata),
    .RAM_RDATA(fx_ram_rdata), .RAM_OE(fx_oe), .RAM_WE(fx_we),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1), .WR0(WR0), .WR1(WR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
`ifdef DATABREAK_MEMINC_EN
    .INC0(INC0), .INC1(INC1), .OVF(fx_ovf),
`endif
    .ACK0(fx_ack0), .ACK1(fx_ack1), .RDATA(fx_rdata), .ERR(fx_err));

  typedef struct {
    logic        id;
    logic        wr;
    logic [11:0] addr;
    logic [11:0] wdata;
    int          d;
    logic        halt;
    logic        hold;
    logic        tmo;
    logic [11:0] exp_rdata;
  } vec_t;

  vec_t tv [0:10];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs();
    return {CPU_STALL, BUS_OWN, RAM_OE, RAM_WE, ACK0, ACK1, ERR};
  endfunction

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0; BRK_OK = 0; CPU_HALTED = 0;
    ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
`ifdef DATABREAK_MEMINC_EN
    INC0 = 0; INC1 = 0;
`endif
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int last;
    logic [6:0] e;
    if (v.id) begin REQ1 = 1; ADDR1 = v.addr; WR1 = v.wr; WDATA1 = v.wdata; end
    else      begin REQ0 = 1; ADDR0 = v.addr; WR0 = v.wr; WDATA0 = v.wdata; end
    last = v.tmo ? 16 : v.d + 4;
    for (int c = 0; c <= last; c++) begin
      step();
      if (v.tmo)
        e = {c <= 14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c == 15};
      else
        e = {c <= v.d + 2, (c == v.d + 1) || (c == v.d + 2), (c == v.d + 1) && !v.wr,
             (c == v.d + 1) && v.wr, (c == v.d + 3) && !v.id, (c == v.d + 3) && v.id, 1'b0};
      check($sformatf("vec%0d_cyc%0d", n, c), 16'(obs()), 16'(e));
      if (!v.tmo && c == v.d + 1) begin
        check($sformatf("vec%0d_addr", n), 16'(RAM_ADDR), 16'(v.addr));
        if (v.wr) check($sformatf("vec%0d_wdata", n), 16'(RAM_WDATA), 16'(v.wdata));
      end
      if (!v.tmo && c == v.d + 3 && !v.wr)
        check($sformatf("vec%0d_rdata", n), 16'(RDATA), 16'(v.exp_rdata));
      if (c == 0 && !v.hold) begin REQ0 = 0; REQ1 = 0; end
      if (c == v.d) begin
        if (v.halt) CPU_HALTED = 1;
        else        BRK_OK = 1;
      end
      if (c == v.d + 3) begin REQ0 = 0; REQ1 = 0; BRK_OK = 0; CPU_HALTED = 0; end
    end
    idle_inputs();
  endtask

  initial begin
    int order [0:3];
    int nacks, lowcnt, fx0, fx1;
    bit seen;
    tv[0]  = '{1'b0, 1'b1, 12'o0200, 12'o1234, 0,   1'b0, 1'b1, 1'b0, 12'o0000};
    tv[1]  = '{1'b1, 1'b0, 12'o0200, 12'o0000, 5,   1'b0, 1'b1, 1'b0, 12'o1234};
    tv[2]  = '{1'b1, 1'b1, 12'o0777, 12'o0055, 2,   1'b1, 1'b1, 1'b0, 12'o0000};
    tv[3]  = '{1'b0, 1'b0, 12'o0777, 12'o0000, 0,   1'b1, 1'b0, 1'b0, 12'o0055};
    tv[4]  = '{1'b0, 1'b1, 12'o0200, 12'o7777, 100, 1'b0, 1'b0, 1'b1, 12'o0000};
    tv[5]  = '{1'b1, 1'b0, 12'o0200, 12'o0000, 0,   1'b0, 1'b1, 1'b0, 12'o1234};
    tv[6]  = '{1'b0, 1'b1, 12'o7777, 12'o4321, 1,   1'b0, 1'b1, 1'b0, 12'o0000};
    tv[7]  = '{1'b1, 1'b0, 12'o7777, 12'o0000, 3,   1'b1, 1'b1, 1'b0, 12'o4321};
    tv[8]  = '{1'b0, 1'b1, 12'o0000, 12'o0001, 0,   1'b0, 1'b1, 1'b0, 12'o0000};
    tv[9]  = '{1'b0, 1'b0, 12'o0000, 12'o0000, 0,   1'b0, 1'b1, 1'b0, 12'o0001};
    tv[10] = '{1'b1, 1'b1, 12'o0300, 12'o7777, 0,   1'b0, 1'b1, 1'b0, 12'o0000};
    fx_ram_rdata = 12'd0;

    idle_inputs();
    RESET = 1;
    step();
    check("reset_outs", 16'(obs()), 16'd0);
    check("reset_rdata", 16'(RDATA), 16'd0);
    RESET = 0;
    step();
    check("idle_outs", 16'(obs()), 16'd0);

    for (int i = 0; i <= 10; i++) run_vec(tv[i], i);

    // Both requesters held after a reset: alternate service, stall gaps between breaks.
    RESET = 1; step(); RESET = 0;
    check("rr_reset_rdata", 16'(RDATA), 16'd0);
    REQ0 = 1; ADDR0 = 12'o0200; REQ1 = 1; ADDR1 = 12'o0777; BRK_OK = 1;
    nacks = 0; lowcnt = 0; fx0 = 0; fx1 = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (fx_ack0) fx0++;
      if (fx_ack1) fx1++;
      if (ACK0 || ACK1) begin
        if (nacks < 4) order[nacks] = ACK1 ? 1 : 0;
        if (nacks > 0) check("rr_stall_gap", 16'(lowcnt >= 1), 16'd1);
        check("rr_rdata", 16'(RDATA), ACK1 ? 16'o0055 : 16'o1234);
        nacks++;
        lowcnt = 0;
      end else if (!CPU_STALL) lowcnt++;
    end
    check("rr_nacks", 16'(nacks >= 4), 16'd1);
    for (int k = 0; k < 4; k++)
      if (k < nacks) check($sformatf("rr_order%0d", k), 16'(order[k]), 16'(k % 2));
    check("fx_ack1_count", 16'(fx1), 16'd0);
    check("fx_ack0_count", 16'(fx0 >= 4), 16'd1);
    idle_inputs();
    for (int c = 0; c < 6; c++) step();
    check("rr_drain", 16'(obs()), 16'd0);

    // Reset while the write strobe is up.
    REQ0 = 1; WR0 = 1; ADDR0 = 12'o0400; WDATA0 = 12'o5555; BRK_OK = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (RAM_WE) seen = 1;
    end
    check("rst_we_seen", 16'(seen), 16'd1);
    RESET = 1;
    step();
    check("rst_mid_outs", 16'(obs()), 16'd0);
    RESET = 0; idle_inputs();
    step();
    check("rst_after_outs", 16'(obs()), 16'd0);

`ifdef DATABREAK_MEMINC_EN
    begin
      logic [6:0] ex [0:4];
      ex[0] = 7'b1000000; ex[1] = 7'b1110000; ex[2] = 7'b1100000;
      ex[3] = 7'b1101000; ex[4] = 7'b0000100;
      REQ0 = 1; WR0 = 0; INC0 = 1; ADDR0 = 12'o0300; BRK_OK = 1;
      for (int c = 0; c < 5; c++) begin
        step();
        check($sformatf("inc_cyc%0d", c), 16'(obs()), 16'(ex[c]));
        check($sformatf("inc_ovf%0d", c), 16'(OVF), 16'(c == 4));
        if (c == 3) check("inc_wdata", 16'(RAM_WDATA), 16'd0);
        if (c == 4) begin
          check("inc_rdata", 16'(RDATA), 16'd0);
          idle_inputs();
        end
      end
      run_vec('{1'b0, 1'b0, 12'o0300, 12'o0000, 0, 1'b0, 1'b1, 1'b0, 12'o0000}, 99);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/databreak_ctrl.md
Name: databreak_ctrl

Overview:
Data-break (DMA) controller that shares the single RAM port between the CPU and two data-break requesters, such as a fast loader and a disk/paper-tape device.
- Stalls the CPU sequencer only at an instruction boundary.
- Takes ownership of the RAM address and data buses and performs one single-word read or write.
- Returns the bus to the CPU afterwards.
- Sits between the sequencer, the RAM and the bus drivers; the CPU's own RAM enables are gated off while BUS_OWN is high.

Parameters:
PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.
STALL_MAX, 15, maximum cycles to wait for BRK_OK before the pending request is dropped; 0 disables the timeout.

Ports:
SYSCLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
BRK_OK  in  1  CPU at instruction boundary (fetch strobe), break may be taken
CPU_HALTED  in  1  CPU stopped; break taken without BRK_OK
CPU_STALL  out  1  freezes sequencer advance
BUS_OWN  out  1  controller drives RAM addr/data; CPU drivers tri-stated
RAM_ADDR  out  12  RAM address when BUS_OWN
RAM_WDATA  out  12  write data when BUS_OWN
RAM_RDATA  in  12  RAM read data, valid 1 cycle after RAM_OE
RAM_OE  out  1  RAM read enable
RAM_WE  out  1  RAM write enable
REQ0, REQ1  in  1  break request
ADDR0, ADDR1  in  12  word address
WR0, WR1  in  1  1 = write, 0 = read
WDATA0, WDATA1  in  12  write data
ACK0, ACK1  out  1  one-cycle completion pulse
RDATA  out  12  read data; valid with ACKn, held until the next read completes
ERR  out  1  one-cycle pulse on stall timeout

Behaviour:
- Reset: every output is 0, state is IDLE, round-robin pointer favours requester 0, and RDATA is 0. RESET during any state forces this at the next edge and never leaves RAM_WE high for an extra cycle.
- Handshake:
  - Requester holds REQn, ADDRn, WRn and WDATAn stable until ACKn.
  - ACKn is high for exactly one cycle.
  - REQn still high the cycle after ACKn is treated as a new request.
- IDLE: when any REQ is high, latch the winner, its ADDR/WR/WDATA and a grant id.
  - Round-robin: winner is the requester not served last.
  - Fixed priority: requester 0 wins.
  - Assert CPU_STALL and go to WAITBRK.
- WAITBRK: CPU_STALL stays 1.
  - BRK_OK or CPU_HALTED → ADDR.
  - Otherwise count cycles; when the count reaches STALL_MAX (nonzero), pulse ERR, drop the request without ACK, go to IDLE.
- ADDR: BUS_OWN=1, RAM_ADDR = latched address.
  - Read: RAM_OE=1.
  - Write: RAM_WE=1, RAM_WDATA = latched data.
  - → DATA.
- DATA: BUS_OWN=1.
  - Read: capture RAM_RDATA into RDATA.
  - → ACK.
- ACK: pulse ACKn for the granted requester, BUS_OWN=0, CPU_STALL=0, update the round-robin pointer, → IDLE.
- Latency from grant to ACK is 3 cycles when BRK_OK is already high.
- Minimum spacing between breaks is 1 IDLE cycle, so the CPU always gets at least one unstalled cycle between breaks.
- Simultaneous REQ0 and REQ1 in IDLE: one is granted and the other waits in IDLE. The loser is served next under round-robin.
- A REQ dropped after being latched is ignored; the transaction completes and ACK still pulses.
- Address has 12 bits with no wrap logic; the requester owns address increments.
- RAM_OE and RAM_WE are never high in the same cycle and never high when BUS_OWN=0.

Optional Feature:
DATABREAK_MEMINC_EN
- Defined: adds inputs INC0 and INC1. A request with INCn=1 and WRn=0 performs a read-increment-write, PDP-8 three-cycle style: ADDR(read) → DATA(capture) → WRITE (RAM_WE=1, RAM_WDATA = RDATA+1 mod 4096) → ACK.
- RDATA returns the incremented value. Output OVF is high with ACKn when the result wrapped to 0000.
- Undefined: no INC or OVF ports exist, and all requests are single-word.

Test Plan:
- REQ0, WR0=1, ADDR0=0200, WDATA0=1234, BRK_OK=1 → RAM_WE for 1 cycle at 0200 with data 1234; ACK0 3 cycles after grant; later read of 0200 gives RDATA=1234.
- REQ1 read at 0200 with BRK_OK=0 for 5 cycles → CPU_STALL high throughout; RAM_OE only after BRK_OK rises; RDATA=1234 with ACK1.
- REQ0 and REQ1 both held high, PRIO_FIXED=0 → ACK order 0,1,0,1; CPU_STALL low ≥1 cycle between breaks. With PRIO_FIXED=1 → only ACK0 while REQ0 is held.
- BRK_OK=0, CPU_HALTED=0, STALL_MAX=15 → ERR pulse 15 cycles after grant; no ACK, no RAM_WE, CPU_STALL low afterwards.
- RESET asserted in ADDR state of a write → next cycle RAM_WE=0, BUS_OWN=0, CPU_STALL=0, no ACK.
- DATABREAK_MEMINC_EN: memory at 0300 holds 7777, INC0=1 → memory becomes 0000, RDATA=0000, OVF=1 with ACK0.
